stream_serializer_eof: RTL and testbench

//  Converts one wide word of Ratio elements into Ratio consecutive narrow valid

---
 rtl/stream_serializer_eof_if.sv | 28 ++
 rtl/stream_serializer_eof.sv | 89 ++++++++
 tb/tb_stream_serializer_eof.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_serializer_eof_if.sv
// Handshake bundle for the EOF serializer: wide word in, narrow element out.
interface stream_serializer_eof_if #(
    parameter int unsigned DataBits = 8,
    parameter int unsigned Ratio    = 2
);
    localparam int unsigned CntBits  = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam int unsigned WordBits = Ratio * DataBits;

    logic                in_valid;
    logic                in_ready;
    logic [WordBits-1:0] in_data;
    logic                in_eof;
    logic [CntBits-1:0]  in_count;
    logic                out_valid;
    logic                out_ready;
    logic [DataBits-1:0] out_data;
    logic                out_eof;

    modport master (
        output in_valid, in_data, in_eof, in_count, out_ready,
        input  in_ready, out_valid, out_data, out_eof
    );

    modport slave (
        input  in_valid, in_data, in_eof, in_count, out_ready,
        output in_ready, out_valid, out_data, out_eof
    );
endinterface

// File: rtl/stream_serializer_eof.sv
// Splits a wide word into Ratio narrow elements (LSB first); a short final word
// emits only in_count+1 elements and flags the last one with out_eof.
module stream_serializer_eof #(
    parameter int unsigned DataBits = 8,
    parameter int unsigned Ratio    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stream_serializer_eof_if.slave bus
);
    localparam int unsigned CntBits  = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam int unsigned WordBits = Ratio * DataBits;
    localparam logic [CntBits-1:0] LastIdx = CntBits'(Ratio - 1);

    logic                out_valid_q, out_valid_d;
    logic [DataBits-1:0] out_data_q,  out_data_d;
    logic                out_eof_q,   out_eof_d;
    logic [CntBits-1:0]  idx_q,       idx_d;
    logic [CntBits-1:0]  lim_q,       lim_d;
    logic                word_eof_q,  word_eof_d;
    logic [WordBits-1:0] hold_q,      hold_d;

    logic                last_c;
    logic                in_ready_c;
    logic [CntBits-1:0]  load_lim_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eof_q   <= 1'b0;
            idx_q       <= '0;
            lim_q       <= '0;
            word_eof_q  <= 1'b0;
            hold_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eof_q   <= out_eof_d;
            idx_q       <= idx_d;
            lim_q       <= lim_d;
            word_eof_q  <= word_eof_d;
            hold_q      <= hold_d;
        end
    end

    // Remaining elements shift down through hold_q so the next one is always at the bottom.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eof_d   = out_eof_q;
        idx_d       = idx_q;
        lim_d       = lim_q;
        word_eof_d  = word_eof_q;
        hold_d      = hold_q;

        last_c     = (idx_q == lim_q);
        in_ready_c = !out_valid_q || (bus.out_ready && last_c);
        load_lim_c = LastIdx;
        if (bus.in_eof && (bus.in_count < LastIdx)) begin
            load_lim_c = bus.in_count;
        end

        if (bus.in_valid && in_ready_c) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[DataBits-1:0];
            idx_d       = '0;
            lim_d       = load_lim_c;
            word_eof_d  = bus.in_eof;
            out_eof_d   = bus.in_eof && (load_lim_c == '0);
            hold_d      = bus.in_data >> DataBits;
        end else if (out_valid_q && bus.out_ready) begin
            if (!last_c) begin
                idx_d      = idx_q + CntBits'(1);
                out_data_d = hold_q[DataBits-1:0];
                hold_d     = hold_q >> DataBits;
                out_eof_d  = word_eof_q && ((idx_q + CntBits'(1)) == lim_q);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_eof   = out_eof_q;

endmodule

// File: tb/tb_stream_serializer_eof.sv
// Bench for stream_serializer_eof: directed sequences, table vectors and a random
// scoreboard run on a Ratio=4 instance, plus a clamp sequence on a Ratio=3 instance.
module tb_stream_serializer_eof;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_serializer_eof_if #(.DataBits(8), .Ratio(4)) bus4 ();
    stream_serializer_eof_if #(.DataBits(8), .Ratio(3)) bus3 ();

    stream_serializer_eof #(.DataBits(8), .Ratio(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    stream_serializer_eof #(.DataBits(8), .Ratio(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } elem_t;

    typedef struct {
        logic [31:0] d;
        logic        eof;
        logic [1:0]  cnt;
        int          n;
        logic [7:0]  x0, x1, x2, x3;
    } vec_t;

    elem_t sbq[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  mon_en   = 1'b0;
    logic  rdy_rand_en = 1'b0;
    logic  rdy_rand = 1'b1;
    logic  rdy_fixed = 1'b1;

    assign bus4.out_ready = rdy_rand_en ? rdy_rand : rdy_fixed;
    assign bus3.out_ready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: every element taken downstream must match the queue head.
    always @(negedge clk) begin
        if (mon_en && bus4.out_valid && bus4.out_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL sb_extra: got 0x%0h with no element expected", bus4.out_data);
            end else begin
                elem_t e;
                e = sbq.pop_front();
                check("sb_data", 32'(bus4.out_data), 32'(e.d));
                check("sb_eof", 32'(bus4.out_eof), 32'(e.e));
            end
        end
    end

    task automatic push_word(input logic [31:0] d, input logic eof, input int n);
        for (int i = 0; i < n; i++) begin
            elem_t e;
            e.d = d[i*8 +: 8];
            e.e = eof && (i == n - 1);
            sbq.push_back(e);
        end
    endtask

    // Present a word and hold it until accepted; returns at posedge+1 after acceptance.
    task automatic send(input logic [31:0] d, input logic eof, input logic [1:0] cnt);
        int t;
        bus4.in_valid = 1'b1;
        bus4.in_data  = d;
        bus4.in_eof   = eof;
        bus4.in_count = cnt;
        t = 0;
        @(negedge clk);
        while (!bus4.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus4.in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for word 0x%0h", d);
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    vec_t vecs[6];

    initial begin
        int t;
        int vcnt;
        vecs[0] = '{32'h44332211, 1'b0, 2'd0, 4, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[1] = '{32'h88776655, 1'b1, 2'd1, 2, 8'h55, 8'h66, 8'h00, 8'h00};
        vecs[2] = '{32'hDDCCBBAA, 1'b1, 2'd3, 4, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        vecs[3] = '{32'h0F0E0D0C, 1'b1, 2'd0, 1, 8'h0C, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{32'h04030201, 1'b0, 2'd2, 4, 8'h01, 8'h02, 8'h03, 8'h04};
        vecs[5] = '{32'hF1E2D3C4, 1'b1, 2'd2, 3, 8'hC4, 8'hD3, 8'hE2, 8'h00};

        bus4.in_valid = 1'b1;
        bus4.in_data  = 32'hDEADBEEF;
        bus4.in_eof   = 1'b1;
        bus4.in_count = 2'd0;
        bus3.in_valid = 1'b0;
        bus3.in_data  = '0;
        bus3.in_eof   = 1'b0;
        bus3.in_count = '0;

        // Reset held with a word offered
        repeat (3) step();
        @(negedge clk);
        check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_out_data", 32'(bus4.out_data), 32'd0);
        check("rst_out_eof", 32'(bus4.out_eof), 32'd0);
        bus4.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus4.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        step();

        // Full non-eof word, out_ready=1
        bus4.in_valid = 1'b1;
        bus4.in_data  = 32'h44332211;
        bus4.in_eof   = 1'b0;
        step();
        bus4.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("w4_valid", 32'(bus4.out_valid), 32'd1);
            check("w4_data", 32'(bus4.out_data), 32'(8'h11 * (k + 1)));
            check("w4_eof", 32'(bus4.out_eof), 32'd0);
            check("w4_in_ready", 32'(bus4.in_ready), 32'(k == 3));
            step();
        end
        @(negedge clk);
        check("w4_idle", 32'(bus4.out_valid), 32'd0);
        step();

        // Back-to-back words, second is short eof
        bus4.in_valid = 1'b1;
        bus4.in_data  = 32'h44332211;
        bus4.in_eof   = 1'b0;
        bus4.in_count = 2'd0;
        step();
        bus4.in_data  = 32'h88776655;
        bus4.in_eof   = 1'b1;
        bus4.in_count = 2'd1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("b2b_valid", 32'(bus4.out_valid), 32'd1);
            check("b2b_data", 32'(bus4.out_data), 32'(8'h11 * (k + 1)));
            check("b2b_eof", 32'(bus4.out_eof), 32'(k == 5));
            step();
            if (k == 3) bus4.in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_no_tail", 32'(bus4.out_valid), 32'd0);
        step();

        // Backpressure: out_ready 1,0,0,1 on a two-element frame
        bus4.in_valid = 1'b1;
        bus4.in_data  = 32'hDDCCBBAA;
        bus4.in_eof   = 1'b1;
        bus4.in_count = 2'd1;
        step();
        bus4.in_valid = 1'b0;
        @(negedge clk);
        check("bp_first", 32'(bus4.out_data), 32'hAA);
        check("bp_first_eof", 32'(bus4.out_eof), 32'd0);
        step();
        rdy_fixed = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus4.out_valid), 32'd1);
            check("bp_hold_data", 32'(bus4.out_data), 32'hBB);
            check("bp_hold_eof", 32'(bus4.out_eof), 32'd1);
            check("bp_in_ready", 32'(bus4.in_ready), 32'd0);
            step();
        end
        rdy_fixed = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(bus4.in_ready), 32'd1);
        step();
        @(negedge clk);
        check("bp_done_valid", 32'(bus4.out_valid), 32'd0);
        check("bp_done_data_held", 32'(bus4.out_data), 32'hBB);
        step();

        // Clamp on Ratio=3: in_count=3 is out of range
        bus3.in_valid = 1'b1;
        bus3.in_data  = 24'h332211;
        bus3.in_eof   = 1'b1;
        bus3.in_count = 2'd3;
        step();
        bus3.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("r3_valid", 32'(bus3.out_valid), 32'd1);
            check("r3_data", 32'(bus3.out_data), 32'(8'h11 * (k + 1)));
            check("r3_eof", 32'(bus3.out_eof), 32'(k == 2));
            step();
        end
        @(negedge clk);
        check("r3_idle", 32'(bus3.out_valid), 32'd0);
        step();

        // Table vectors with random backpressure
        mon_en = 1'b1;
        rdy_rand_en = 1'b1;
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            push_word({v.x3, v.x2, v.x1, v.x0}, v.eof, v.n);
            send(v.d, v.eof, v.cnt);
        end

        // Random frames against the reference model
        for (int f = 0; f < 1000; f++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                logic [31:0] d;
                logic        eof;
                logic [1:0]  cnt;
                d   = $urandom;
                eof = (w == nw - 1);
                cnt = 2'($urandom_range(0, 3));
                push_word(d, eof, eof ? int'(cnt) + 1 : 4);
                repeat ($urandom_range(0, 2)) step();
                send(d, eof, cnt);
            end
        end
        t = 0;
        while (sbq.size() != 0 && t < 2000) begin
            step();
            t++;
        end
        check("sb_drained", 32'(sbq.size()), 32'd0);
        mon_en = 1'b0;
        rdy_rand_en = 1'b0;
        rdy_fixed = 1'b1;
        repeat (2) step();

        // Reset in the middle of a word
        bus4.in_valid = 1'b1;
        bus4.in_data  = 32'h44332211;
        bus4.in_eof   = 1'b0;
        step();
        bus4.in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus4.out_valid), 32'd0);
        check("midrst_data", 32'(bus4.out_data), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus4.in_ready), 32'd1);
        vcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus4.out_valid) vcnt++;
        end
        check("midrst_no_output", 32'(vcnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
